// File: rtl/psd_demod_nch.sv
// psd_demod_nch: N-channel sigma-delta phase-sensitive demodulator with delayed
// quadrature reference, accumulate-and-dump decimation and a valid/ready word serialiser.
module psd_demod_nch #(
  parameter int N_CH = 2,
  parameter int SIN_WIDTH = 16,
  parameter int DELAY_BITS = 5,
  parameter int DEC_BITS = 10,
  parameter int O_WIDTH = 16,
  localparam int ACC_WIDTH = SIN_WIDTH + 1 + DEC_BITS,
  localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [N_CH-1:0]             i_sd,
  input  logic signed [SIN_WIDTH-1:0] i_sin,
  input  logic signed [SIN_WIDTH-1:0] i_cos,
  input  logic [DELAY_BITS-1:0]       i_delay,
  output logic signed [O_WIDTH-1:0]   o_data,
  output logic [CH_BITS-1:0]          o_ch,
  output logic                        o_iq,
  output logic                        o_last,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_overrun
);
  localparam int HLEN = 2**DELAY_BITS - 1;
  localparam logic [CH_BITS:0] LAST = (CH_BITS+1)'(2*N_CH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  logic signed [SIN_WIDTH-1:0] h_sin [HLEN];
  logic signed [SIN_WIDTH-1:0] h_cos [HLEN];
  logic signed [SIN_WIDTH-1:0] r_sin, r_cos;
  logic signed [SIN_WIDTH:0]   x_sin, x_cos;
  logic signed [SIN_WIDTH:0]   p_i [N_CH];
  logic signed [SIN_WIDTH:0]   p_q [N_CH];
  logic signed [ACC_WIDTH-1:0] acc_i [N_CH];
  logic signed [ACC_WIDTH-1:0] acc_q [N_CH];
  logic signed [ACC_WIDTH-1:0] sum_i [N_CH];
  logic signed [ACC_WIDTH-1:0] sum_q [N_CH];
  logic signed [O_WIDTH-1:0]   bank_i [N_CH];
  logic signed [O_WIDTH-1:0]   bank_q [N_CH];
  logic [DEC_BITS-1:0] cnt;
  logic p_last, dump_pending, load, hs, at_last, overrun_nxt;
  logic [CH_BITS:0] idx, idx_nxt;
  state_t state, state_nxt;
  // D=0 is the live reference; h_*[k-1] holds the pair from k enabled cycles ago
  assign r_sin = (i_delay == '0) ? i_sin : h_sin[i_delay - 1'b1];
  assign r_cos = (i_delay == '0) ? i_cos : h_cos[i_delay - 1'b1];
  assign x_sin = {r_sin[SIN_WIDTH-1], r_sin};
  assign x_cos = {r_cos[SIN_WIDTH-1], r_cos};
  assign load = i_en & p_last;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < HLEN; i++) begin
        h_sin[i] <= '0;
        h_cos[i] <= '0;
      end
    end else if (i_en) begin
      h_sin[0] <= i_sin;
      h_cos[0] <= i_cos;
      for (int i = 1; i < HLEN; i++) begin
        h_sin[i] <= h_sin[i-1];
        h_cos[i] <= h_cos[i-1];
      end
    end
  // A frame's first add must discard the previous total, already captured in the bank
  always_comb
    for (int k = 0; k < N_CH; k++) begin
      sum_i[k] = (dump_pending ? '0 : acc_i[k]) + {{DEC_BITS{p_i[k][SIN_WIDTH]}}, p_i[k]};
      sum_q[k] = (dump_pending ? '0 : acc_q[k]) + {{DEC_BITS{p_q[k][SIN_WIDTH]}}, p_q[k]};
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      p_last <= 1'b0;
      dump_pending <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        p_i[k] <= '0;
        p_q[k] <= '0;
        acc_i[k] <= '0;
        acc_q[k] <= '0;
        bank_i[k] <= '0;
        bank_q[k] <= '0;
      end
    end else if (i_en) begin
      cnt <= cnt + 1'b1;
      p_last <= &cnt;
      dump_pending <= p_last;
      for (int k = 0; k < N_CH; k++) begin
        p_i[k] <= i_sd[k] ? x_sin : -x_sin;
        p_q[k] <= i_sd[k] ? x_cos : -x_cos;
        acc_i[k] <= sum_i[k];
        acc_q[k] <= sum_q[k];
        if (p_last) begin
          bank_i[k] <= sum_i[k][ACC_WIDTH-1 -: O_WIDTH];
          bank_q[k] <= sum_q[k][ACC_WIDTH-1 -: O_WIDTH];
        end
      end
    end
  assign o_valid = state == SEND;
  assign hs = o_valid & i_ready;
  assign at_last = idx == LAST;
  assign o_ch = idx[CH_BITS:1];
  assign o_iq = idx[0];
  assign o_last = o_valid & at_last;
  assign o_data = o_iq ? bank_q[o_ch] : bank_i[o_ch];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      idx <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      o_overrun <= overrun_nxt;
    end
  // A new bank always restarts at word 0; losing undelivered words is flagged
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    overrun_nxt = o_overrun;
    if (load) begin
      state_nxt = SEND;
      idx_nxt = '0;
      overrun_nxt = o_overrun | (o_valid & ~(hs & at_last));
    end else if (hs) begin
      state_nxt = at_last ? IDLE : SEND;
      idx_nxt = at_last ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_psd_demod_nch.sv
// tb_psd_demod_nch: directed bench with a sample-history model of frame sums and the word stream.
module tb_psd_demod_nch;
  localparam int DEC = 16;
  logic i_clk = 1'b0;
  logic i_rst_n, i_en, i_ready, o_iq, o_last, o_valid, o_overrun;
  logic [1:0] i_sd;
  logic signed [15:0] i_sin, i_cos;
  logic [4:0] i_delay;
  logic signed [20:0] o_data;
  logic [0:0] o_ch;
  int n_pass = 0, n_chk = 0, nsamp = 0, cyc;
  bit ramp = 0;
  int ms [4096];
  int mc [4096];
  int fi [2];
  int fq [2];
  int fw [$];
  int mq [$];
  bit m_pend, m_ovr;
  int m_n, src, rs, rc;

  psd_demod_nch #(.N_CH(2), .SIN_WIDTH(16), .DELAY_BITS(5), .DEC_BITS(4), .O_WIDTH(21)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sd(i_sd), .i_sin(i_sin), .i_cos(i_cos),
    .i_delay(i_delay), .o_data(o_data), .o_ch(o_ch), .o_iq(o_iq), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_overrun(o_overrun));

  always #5 i_clk = ~i_clk;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Model: frame f sums sd-signed reference samples n=16f..16f+15, reference taken at n-D(n)
  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mq.delete();
      m_ovr = 0;
      m_pend = 0;
      m_n = 0;
      fi = '{0, 0};
      fq = '{0, 0};
    end else begin
      if (mq.size() > 0 && i_ready) void'(mq.pop_front());
      if (i_en) begin
        if (m_pend) begin
          if (mq.size() > 0) m_ovr = 1;
          mq = fw;
          m_pend = 0;
        end
        ms[m_n] = int'(i_sin);
        mc[m_n] = int'(i_cos);
        src = m_n - int'(i_delay);
        rs = (src >= 0) ? ms[src] : 0;
        rc = (src >= 0) ? mc[src] : 0;
        for (int k = 0; k < 2; k++) begin
          fi[k] += i_sd[k] ? rs : -rs;
          fq[k] += i_sd[k] ? rc : -rc;
        end
        if (m_n % DEC == DEC - 1) begin
          fw = '{fi[0], fq[0], fi[1], fq[1]};
          fi = '{0, 0};
          fq = '{0, 0};
          m_pend = 1;
        end
        m_n++;
      end
    end

  always @(negedge i_clk)
    if (i_rst_n) begin
      check("valid", int'(o_valid), int'(mq.size() > 0));
      check("overrun", int'(o_overrun), int'(m_ovr));
      if (mq.size() > 0) begin
        check("data", int'(o_data), mq[0]);
        check("ch", int'(o_ch), (4 - mq.size()) / 2);
        check("iq", int'(o_iq), (4 - mq.size()) % 2);
        check("last", int'(o_last), int'(mq.size() == 1));
      end
    end

  task automatic tick();
    @(posedge i_clk);
    if (i_en && i_rst_n) nsamp++;
    @(negedge i_clk);
    if (ramp) i_sin = nsamp[15:0];
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    nsamp = 0;
    if (ramp) i_sin = '0;
    i_rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!o_valid && c < 100) begin
      tick();
      c++;
    end
    if (!o_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic dc();
    ramp = 0;
    i_en = 1'b1;
    i_sd = 2'b01;
    i_sin = 16'sd1000;
    i_cos = -16'sd500;
    i_delay = '0;
  endtask

  initial begin
    int exp_w [4] = '{16000, -8000, -16000, 8000};
    dc();
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("rst_data", int'(o_data), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_ovr", int'(o_overrun), 0);
    // DC accumulate, full-rate streaming
    do_reset();
    wait_valid(cyc);
    check("first_valid_cycles", cyc, 17);
    for (int w = 0; w < 4; w++) begin
      check("dc_data", int'(o_data), exp_w[w]);
      check("dc_ch", int'(o_ch), w / 2);
      check("dc_iq", int'(o_iq), w % 2);
      check("dc_last", int'(o_last), int'(w == 3));
      tick();
    end
    check("dc_idle", int'(o_valid), 0);
    // Reference delay on a ramp
    ramp = 1;
    i_cos = '0;
    i_delay = 5'd3;
    do_reset();
    wait_valid(cyc);
    check("delay3_sum", int'(o_data), 78);
    i_delay = '0;
    do_reset();
    wait_valid(cyc);
    check("delay0_sum", int'(o_data), 120);
    // Backpressure
    dc();
    i_ready = 1'b0;
    do_reset();
    wait_valid(cyc);
    repeat (10) begin
      tick();
      check("bp_valid", int'(o_valid), 1);
      check("bp_ch", int'(o_ch), 0);
      check("bp_iq", int'(o_iq), 0);
      check("bp_data", int'(o_data), 16000);
    end
    i_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      check("bp_word", int'(o_data), exp_w[w]);
      tick();
    end
    check("bp_idle", int'(o_valid), 0);
    // Overrun after partial delivery
    i_ready = 1'b0;
    do_reset();
    wait_valid(cyc);
    i_ready = 1'b1;
    tick();
    tick();
    i_ready = 1'b0;
    check("ovr_pre_ch", int'(o_ch), 1);
    cyc = 0;
    while (!o_overrun && cyc < 40) begin
      tick();
      cyc++;
    end
    check("ovr_set", int'(o_overrun), 1);
    check("ovr_ch", int'(o_ch), 0);
    check("ovr_iq", int'(o_iq), 0);
    check("ovr_data", int'(o_data), 16000);
    // Load coinciding with the last-word handshake
    do_reset();
    wait_valid(cyc);
    repeat (12) tick();
    i_ready = 1'b1;
    repeat (4) tick();
    check("coin_valid", int'(o_valid), 1);
    check("coin_ch", int'(o_ch), 0);
    check("coin_ovr", int'(o_overrun), 0);
    repeat (4) tick();
    check("coin_idle", int'(o_valid), 0);
    check("coin_ovr2", int'(o_overrun), 0);
    // Enable gating mid-frame
    do_reset();
    repeat (8) tick();
    i_en = 1'b0;
    repeat (5) tick();
    i_en = 1'b1;
    wait_valid(cyc);
    check("gated_cycles", cyc + 13, 22);
    check("gated_i0", int'(o_data), 16000);
    tick();
    check("gated_q0", int'(o_data), -8000);
    // Asynchronous reset in the middle of SEND
    i_ready = 1'b0;
    do_reset();
    wait_valid(cyc);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_data", int'(o_data), 0);
    check("arst_ch", int'(o_ch), 0);
    check("arst_iq", int'(o_iq), 0);
    check("arst_last", int'(o_last), 0);
    check("arst_valid", int'(o_valid), 0);
    check("arst_ovr", int'(o_overrun), 0);
    do_reset();
    wait_valid(cyc);
    check("arst_first_valid", cyc, 17);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
